// File: rtl/object_extent_tracker_pkg.sv
// Shared definitions for the object extent tracker slice.
// Holds RGB565 field positions, default colour-window thresholds, the
// tracker state encoding, coordinate/centre widths and the centre-sum helper.
package object_extent_tracker_pkg;

  localparam int COORD_W  = 10;
  localparam int CENTRE_W = 12;
  localparam int COUNT_W  = 19;

  // RGB565 field slices
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;

  // Default colour window and publish threshold
  localparam logic [4:0]         R_MIN_DEF      = 5'd20;
  localparam logic [5:0]         G_MAX_DEF      = 6'd24;
  localparam logic [4:0]         B_MAX_DEF      = 5'd12;
  localparam logic [COUNT_W-1:0] MIN_PIXELS_DEF = 19'd64;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_SCAN  = 2'd2,
    ST_LATCH = 2'd3
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } coord_t;

  // Sum of four 10-bit coordinates; 4*1023 fits in 12 bits, so no overflow.
  function automatic logic [CENTRE_W-1:0] centre_sum(
    input logic [COORD_W-1:0] a,
    input logic [COORD_W-1:0] b,
    input logic [COORD_W-1:0] c,
    input logic [COORD_W-1:0] d
  );
    return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
  endfunction

endpackage

// File: rtl/object_extent_tracker_if.sv
// Pixel stream bundle shared with the LCD driver.
//   pix_valid  : pixel strobe
//   pix_x/y    : pixel column / row
//   pix_data   : RGB565 pixel
//   frame_sync : vertical sync, active-low
// master drives the stream, slave observes it.
interface object_extent_tracker_if;
  import object_extent_tracker_pkg::*;

  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic [15:0]        pix_data;
  logic               frame_sync;

  modport master (output pix_valid, pix_x, pix_y, pix_data, frame_sync);
  modport slave  (input  pix_valid, pix_x, pix_y, pix_data, frame_sync);

endinterface

// File: rtl/object_extent_tracker_match.sv
// pix_colour_match: registered single-stage RGB565 colour-window classifier.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   pix_valid/x/y/data  : incoming pixel
//   hit_r               : registered pix_valid & colour-window match
//   hit_x_r, hit_y_r    : coordinates registered alongside hit_r
module pix_colour_match
  import object_extent_tracker_pkg::*;
#(
  parameter logic [4:0] R_MIN = R_MIN_DEF,
  parameter logic [5:0] G_MAX = G_MAX_DEF,
  parameter logic [4:0] B_MAX = B_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pix_valid,
  input  logic [COORD_W-1:0] pix_x,
  input  logic [COORD_W-1:0] pix_y,
  input  logic [15:0]        pix_data,
  output logic               hit_r,
  output logic [COORD_W-1:0] hit_x_r,
  output logic [COORD_W-1:0] hit_y_r
);

  logic in_window_s;

  // Colour window test on the raw pixel fields
  always_comb begin
    in_window_s = (pix_data[R_HI:R_LO] >= R_MIN) &&
                  (pix_data[G_HI:G_LO] <= G_MAX) &&
                  (pix_data[B_HI:B_LO] <= B_MAX);
  end

  // Stage-1 register: match flag plus its coordinates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r   <= 1'b0;
      hit_x_r <= 10'd0;
      hit_y_r <= 10'd0;
    end else begin
      hit_r   <= pix_valid & in_window_s;
      hit_x_r <= pix_x;
      hit_y_r <= pix_y;
    end
  end

endmodule

// File: rtl/object_extent_tracker.sv
// object_extent_tracker: per-frame colour-blob extent detector.
// Ports:
//   clk, rst_n        : pixel clock, async active-low reset
//   pix (slave)       : pixel stream + active-low frame_sync
//   top/bottom/left/right_pos_x/y : published extreme matching pixels
//   centre_pos_x/y    : sum of the four extreme coordinates (use [11:2])
//   obj_valid         : last completed frame had at least MIN_PIXELS hits
//   frame_done        : one-cycle pulse when the outputs are refreshed
// Outputs are registers that change only on the frame_done cycle.
module object_extent_tracker
  import object_extent_tracker_pkg::*;
#(
  parameter logic [4:0]         R_MIN      = R_MIN_DEF,
  parameter logic [5:0]         G_MAX      = G_MAX_DEF,
  parameter logic [4:0]         B_MAX      = B_MAX_DEF,
  parameter logic [COUNT_W-1:0] MIN_PIXELS = MIN_PIXELS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  object_extent_tracker_if.slave pix,
  output logic [COORD_W-1:0]  top_pos_x,
  output logic [COORD_W-1:0]  top_pos_y,
  output logic [COORD_W-1:0]  bottom_pos_x,
  output logic [COORD_W-1:0]  bottom_pos_y,
  output logic [COORD_W-1:0]  left_pos_x,
  output logic [COORD_W-1:0]  left_pos_y,
  output logic [COORD_W-1:0]  right_pos_x,
  output logic [COORD_W-1:0]  right_pos_y,
  output logic [CENTRE_W-1:0] centre_pos_x,
  output logic [CENTRE_W-1:0] centre_pos_y,
  output logic                obj_valid,
  output logic                frame_done
);

  logic               hit_r;
  logic [COORD_W-1:0] hit_x_r;
  logic [COORD_W-1:0] hit_y_r;

  logic               fs_q1_r;
  logic               fs_q2_r;
  logic               fall_s;

  state_e             state_r;
  state_e             state_next_s;

  logic               first_seen_r;
  logic [COUNT_W-1:0] count_r;
  coord_t             top_r;
  coord_t             bottom_r;
  coord_t             left_r;
  coord_t             right_r;

  pix_colour_match #(
    .R_MIN (R_MIN),
    .G_MAX (G_MAX),
    .B_MAX (B_MAX)
  ) u_match (
    .clk       (clk),
    .rst_n     (rst_n),
    .pix_valid (pix.pix_valid),
    .pix_x     (pix.pix_x),
    .pix_y     (pix.pix_y),
    .pix_data  (pix.pix_data),
    .hit_r     (hit_r),
    .hit_x_r   (hit_x_r),
    .hit_y_r   (hit_y_r)
  );

  // Two-flop sampling of frame_sync; idles high so reset gives no false edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q1_r <= 1'b1;
      fs_q2_r <= 1'b1;
    end else begin
      fs_q1_r <= pix.frame_sync;
      fs_q2_r <= fs_q1_r;
    end
  end

  assign fall_s = fs_q2_r & ~fs_q1_r;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_WAIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic; the first sync after reset only arms the scan
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_WAIT: begin
        if (fall_s) state_next_s = ST_CLEAR;
        else        state_next_s = ST_WAIT;
      end
      ST_CLEAR: state_next_s = ST_SCAN;
      ST_SCAN: begin
        if (fall_s) state_next_s = ST_LATCH;
        else        state_next_s = ST_SCAN;
      end
      ST_LATCH: state_next_s = ST_SCAN;
      default:  state_next_s = ST_WAIT;
    endcase
  end

  // Working extremes; clear wins over any hit landing in CLEAR or LATCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      first_seen_r <= 1'b0;
      count_r      <= 19'd0;
      top_r        <= '0;
      bottom_r     <= '0;
      left_r       <= '0;
      right_r      <= '0;
    end else begin
      case (state_r)
        ST_CLEAR, ST_LATCH: begin
          first_seen_r <= 1'b0;
          count_r      <= 19'd0;
          top_r        <= '0;
          bottom_r     <= '0;
          left_r       <= '0;
          right_r      <= '0;
        end
        ST_SCAN: begin
          if (hit_r) begin
            if (count_r != {COUNT_W{1'b1}}) begin
              count_r <= count_r + 19'd1;
            end
            if (!first_seen_r) begin
              first_seen_r <= 1'b1;
              top_r        <= '{x: hit_x_r, y: hit_y_r};
              bottom_r     <= '{x: hit_x_r, y: hit_y_r};
              left_r       <= '{x: hit_x_r, y: hit_y_r};
              right_r      <= '{x: hit_x_r, y: hit_y_r};
            end else begin
              // Raster order: the latest hit is always the bottom one;
              // strict compares keep the earliest hit on x ties.
              bottom_r <= '{x: hit_x_r, y: hit_y_r};
              if (hit_x_r < left_r.x) begin
                left_r <= '{x: hit_x_r, y: hit_y_r};
              end
              if (hit_x_r > right_r.x) begin
                right_r <= '{x: hit_x_r, y: hit_y_r};
              end
            end
          end
        end
        default: begin
          // WAIT: pixels ignored, registers already cleared by reset
        end
      endcase
    end
  end

  // Publish stage: refresh outputs once per frame in LATCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_pos_x    <= 10'd0;
      top_pos_y    <= 10'd0;
      bottom_pos_x <= 10'd0;
      bottom_pos_y <= 10'd0;
      left_pos_x   <= 10'd0;
      left_pos_y   <= 10'd0;
      right_pos_x  <= 10'd0;
      right_pos_y  <= 10'd0;
      centre_pos_x <= 12'd0;
      centre_pos_y <= 12'd0;
      obj_valid    <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      if (state_r == ST_LATCH) begin
        frame_done <= 1'b1;
        if (count_r >= MIN_PIXELS) begin
          top_pos_x    <= top_r.x;
          top_pos_y    <= top_r.y;
          bottom_pos_x <= bottom_r.x;
          bottom_pos_y <= bottom_r.y;
          left_pos_x   <= left_r.x;
          left_pos_y   <= left_r.y;
          right_pos_x  <= right_r.x;
          right_pos_y  <= right_r.y;
          centre_pos_x <= centre_sum(top_r.x, bottom_r.x, left_r.x, right_r.x);
          centre_pos_y <= centre_sum(top_r.y, bottom_r.y, left_r.y, right_r.y);
          obj_valid    <= 1'b1;
        end else begin
          // Too few hits: keep the last good positions for the overlay
          obj_valid <= 1'b0;
        end
      end else begin
        frame_done <= 1'b0;
      end
    end
  end

endmodule
